// File: rtl/kernel_mem_bank_pkg.sv
// Shared types and constants for the kernel coefficient store.
// A complex word packs the real part in the upper 32 bits and the imaginary part in the lower 32 bits.
package kernel_mem_bank_pkg;

    localparam int KMEM_ADDR_W = 9;
    localparam int KMEM_DEPTH  = 1 << KMEM_ADDR_W;
    localparam int KMEM_LANES  = 8;
    localparam int KMEM_CPX_W  = 64;

    typedef struct packed {
        logic [31:0] r;
        logic [31:0] i;
    } complex_t;

    typedef enum logic {
        SUB_BANK_LO = 1'b0,
        SUB_BANK_HI = 1'b1
    } sub_bank_e;

endpackage

// File: rtl/kernel_mem_bank_if.sv
// Write/read bus of the kernel coefficient store: one cacheline write port and one full-entry read port.
interface kernel_mem_bank_if #(
    parameter int ADDR_W = kernel_mem_bank_pkg::KMEM_ADDR_W,
    parameter int CPX_W  = kernel_mem_bank_pkg::KMEM_CPX_W,
    parameter int LANES  = kernel_mem_bank_pkg::KMEM_LANES
);
    // No back-pressure: a write is taken on every clock edge where we=1, and the read
    // address is sampled on every edge; out_data carries the entry addressed at the previous edge.
    logic                         we;
    logic                         select;
    logic [ADDR_W-1:0]            write_address;
    logic [ADDR_W-1:0]            read_address;
    logic [LANES*CPX_W-1:0]       in_data;
    logic [2*LANES*CPX_W-1:0]     out_data;

    modport master (
        output we,
        output select,
        output write_address,
        output read_address,
        output in_data,
        input  out_data
    );

    modport slave (
        input  we,
        input  select,
        input  write_address,
        input  read_address,
        input  in_data,
        output out_data
    );

endinterface

// File: rtl/kernel_mem_bank_dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port (read-first on address collision).
// The read register clears asynchronously so the bank output is zero while reset is held.
module kmem_dp_ram #(
    parameter int WIDTH  = 64,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_d;
    logic [WIDTH-1:0] rd_data_q;

    // Storage is deliberately not reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = mem_q[rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/kernel_mem_bank.sv
// Kernel coefficient store: 2 sub-banks x 8 lanes of complex words, half-entry writes, full-entry reads.
// Define KMEM_OUT_PIPE_EN to add a reset-to-zero output register (read latency 2 instead of 1).
module kernel_mem_bank
    import kernel_mem_bank_pkg::*;
#(
    parameter int ADDR_W = KMEM_ADDR_W,
    parameter int CPX_W  = KMEM_CPX_W,
    parameter int LANES  = KMEM_LANES
) (
    input  logic             clk,
    input  logic             reset,
    kernel_mem_bank_if.slave bus
);
    localparam int OUT_W = 2 * LANES * CPX_W;

    logic     we_0;
    logic     we_1;
    complex_t wr_lane [LANES];
    complex_t rd_lane [2*LANES];
    logic [OUT_W-1:0] out_d;

    // Writes are dropped while reset is held; select steers the cacheline to one half only.
    assign we_0 = bus.we & ~reset & (sub_bank_e'(bus.select) == SUB_BANK_LO);
    assign we_1 = bus.we & ~reset & (sub_bank_e'(bus.select) == SUB_BANK_HI);

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            wr_lane[k] = complex_t'(bus.in_data[k*CPX_W +: CPX_W]);
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            kmem_dp_ram #(
                .WIDTH  ($bits(complex_t)),
                .ADDR_W (ADDR_W)
            ) u_ram (
                .clk     (clk),
                .rst     (reset),
                .wr_en   ((b == 0) ? we_0 : we_1),
                .wr_addr (bus.write_address),
                .wr_data (wr_lane[k]),
                .rd_addr (bus.read_address),
                .rd_data (rd_lane[b*LANES + k])
            );
        end
    end

    // Lanes 0..LANES-1 come from the low half, the rest from the high half.
    always_comb begin
        out_d = '0;
        for (int l = 0; l < 2*LANES; l++) begin
            out_d[l*CPX_W +: CPX_W] = rd_lane[l];
        end
    end

`ifdef KMEM_OUT_PIPE_EN
    logic [OUT_W-1:0] out_pipe_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_pipe_q <= '0;
        end else begin
            out_pipe_q <= out_d;
        end
    end

    assign bus.out_data = out_pipe_q;
`else
    assign bus.out_data = out_d;
`endif

endmodule

// File: tb/tb_kernel_mem_bank.sv
// Self-checking bench for kernel_mem_bank: directed scenarios plus a randomized read/write mix
// checked against an array model of the two sub-banks.
module tb_kernel_mem_bank;

    localparam int ADDR_W = 9;
    localparam int CPX_W  = 64;
    localparam int LANES  = 8;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int LW     = LANES * CPX_W;
    localparam int OW     = 2 * LW;
`ifdef KMEM_OUT_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk;
    logic reset;

    int n_vec;
    int n_err;

    logic [LW-1:0] ref_mem [2][DEPTH];

    kernel_mem_bank_if #(.ADDR_W(ADDR_W), .CPX_W(CPX_W), .LANES(LANES)) bus_if ();

    kernel_mem_bank #(.ADDR_W(ADDR_W), .CPX_W(CPX_W), .LANES(LANES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    // ---------------- model helpers ----------------
    function automatic logic [OW-1:0] ref_read(input logic [ADDR_W-1:0] a);
        return {ref_mem[1][a], ref_mem[0][a]};
    endfunction

    function automatic logic [LW-1:0] lane_pat(input logic [31:0] re_base, input logic [31:0] im_base);
        logic [LW-1:0] v;
        for (int k = 0; k < LANES; k++) begin
            v[k*CPX_W +: CPX_W] = {re_base | 32'(k), im_base | 32'(k)};
        end
        return v;
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int i = 0; i < LW/32; i++) begin
            v[i*32 +: 32] = $urandom;
        end
        return v;
    endfunction

    function automatic int bad_lane(input logic [OW-1:0] act, input logic [OW-1:0] exp);
        for (int l = 0; l < 2*LANES; l++) begin
            if (act[l*CPX_W +: CPX_W] !== exp[l*CPX_W +: CPX_W]) return l;
        end
        return 0;
    endfunction

    // ---------------- driver ----------------
    task automatic apply(input logic we, input logic sel, input logic [ADDR_W-1:0] wa,
                         input logic [ADDR_W-1:0] ra, input logic [LW-1:0] d);
        bus_if.we            = we;
        bus_if.select        = sel;
        bus_if.write_address = wa;
        bus_if.read_address  = ra;
        bus_if.in_data       = d;
        @(posedge clk);
        if (we && !reset) ref_mem[sel][wa] = d;
        #1;
        bus_if.we = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [OW-1:0] act;
        reset = 1'b1;
        bus_if.we = 1'b0;
        bus_if.select = 1'b0;
        bus_if.write_address = '0;
        bus_if.read_address = '0;
        bus_if.in_data = '0;
        #1;
        act = bus_if.out_data;
        n_vec++;
        if (act !== '0) begin
            n_err++;
            $display("FAIL reset_initial: lane %0d got %h expected 0", bad_lane(act, '0), act[bad_lane(act, '0)*CPX_W +: CPX_W]);
        end
        repeat (2) @(posedge clk);
        #1;
        act = bus_if.out_data;
        n_vec++;
        if (act !== '0) begin
            n_err++;
            $display("FAIL reset_held: lane %0d got %h expected 0", bad_lane(act, '0), act[bad_lane(act, '0)*CPX_W +: CPX_W]);
        end
        reset = 1'b0;
    endtask

    task automatic test_half_write();
        logic [OW-1:0] exp;
        logic [OW-1:0] act;
        apply(1'b1, 1'b0, 9'd0, 9'd0, lane_pat(32'h1000_0000, 32'h2000_0000));
        apply(1'b1, 1'b1, 9'd0, 9'd0, lane_pat(32'h3000_0000, 32'h4000_0000));
        repeat (LAT) apply(1'b0, 1'b0, 9'd0, 9'd0, '0);
        exp = {lane_pat(32'h3000_0000, 32'h4000_0000), lane_pat(32'h1000_0000, 32'h2000_0000)};
        act = bus_if.out_data;
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL half_write: lane %0d got %h expected %h", bad_lane(act, exp),
                     act[bad_lane(act, exp)*CPX_W +: CPX_W], exp[bad_lane(act, exp)*CPX_W +: CPX_W]);
        end
    endtask

    task automatic test_isolation();
        logic [OW-1:0] exp;
        logic [OW-1:0] act;
        apply(1'b1, 1'b0, 9'd0, 9'd0, {LW{1'b1}});
        repeat (LAT) apply(1'b0, 1'b0, 9'd0, 9'd0, '0);
        exp = {lane_pat(32'h3000_0000, 32'h4000_0000), {LW{1'b1}}};
        act = bus_if.out_data;
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL isolation: lane %0d got %h expected %h", bad_lane(act, exp),
                     act[bad_lane(act, exp)*CPX_W +: CPX_W], exp[bad_lane(act, exp)*CPX_W +: CPX_W]);
        end
    endtask

    task automatic test_two_entries();
        logic [OW-1:0] exp_q[$];
        logic [OW-1:0] exp;
        logic [OW-1:0] act;
        logic [ADDR_W-1:0] a;
        for (int n = 0; n < 4; n++) begin
            apply(1'b1, n[0], ADDR_W'(n / 2), 9'd0, rand_line());
        end
        for (int n = 0; n < 6 + LAT - 1; n++) begin
            a = (n < 6) ? ADDR_W'(n % 2) : 9'd1;
            exp_q.push_back(ref_read(a));
            apply(1'b0, 1'b0, 9'd0, a, '0);
            if (exp_q.size() == LAT) begin
                exp = exp_q.pop_front();
                act = bus_if.out_data;
                n_vec++;
                if (act !== exp) begin
                    n_err++;
                    $display("FAIL two_entries[%0d]: lane %0d got %h expected %h", n, bad_lane(act, exp),
                             act[bad_lane(act, exp)*CPX_W +: CPX_W], exp[bad_lane(act, exp)*CPX_W +: CPX_W]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [OW-1:0] exp;
        logic [OW-1:0] act;
        logic [LW-1:0] last;
        apply(1'b1, 1'b0, 9'd7, 9'd0, rand_line());
        apply(1'b1, 1'b1, 9'd7, 9'd0, rand_line());
        last = rand_line();
        apply(1'b1, 1'b1, 9'd7, 9'd0, last);
        repeat (LAT) apply(1'b0, 1'b0, 9'd0, 9'd7, '0);
        exp = {last, ref_mem[0][7]};
        act = bus_if.out_data;
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL back_to_back: lane %0d got %h expected %h", bad_lane(act, exp),
                     act[bad_lane(act, exp)*CPX_W +: CPX_W], exp[bad_lane(act, exp)*CPX_W +: CPX_W]);
        end
    endtask

    task automatic test_collision();
        logic [OW-1:0] old_v;
        logic [OW-1:0] new_v;
        logic [OW-1:0] act;
        apply(1'b1, 1'b0, 9'd5, 9'd0, rand_line());
        apply(1'b1, 1'b1, 9'd5, 9'd0, rand_line());
        old_v = ref_read(9'd5);
        new_v = {ref_mem[1][5], {(LW/8){8'hA5}}};
        apply(1'b1, 1'b0, 9'd5, 9'd5, {(LW/8){8'hA5}});
        repeat (LAT - 1) apply(1'b0, 1'b0, 9'd0, 9'd5, '0);
        act = bus_if.out_data;
        n_vec++;
        if (act !== old_v) begin
            n_err++;
            $display("FAIL collision_old: lane %0d got %h expected %h", bad_lane(act, old_v),
                     act[bad_lane(act, old_v)*CPX_W +: CPX_W], old_v[bad_lane(act, old_v)*CPX_W +: CPX_W]);
        end
        apply(1'b0, 1'b0, 9'd0, 9'd5, '0);
        act = bus_if.out_data;
        n_vec++;
        if (act !== new_v) begin
            n_err++;
            $display("FAIL collision_new: lane %0d got %h expected %h", bad_lane(act, new_v),
                     act[bad_lane(act, new_v)*CPX_W +: CPX_W], new_v[bad_lane(act, new_v)*CPX_W +: CPX_W]);
        end
    endtask

    task automatic test_wrap();
        logic [OW-1:0] exp;
        logic [OW-1:0] act;
        apply(1'b1, 1'b1, 9'h1FF, 9'd0, rand_line());
        apply(1'b1, 1'b0, 9'h1FF, 9'd0, {(LW/32){32'hDEAD_BEEF}});
        repeat (LAT) apply(1'b0, 1'b0, 9'd0, 9'h1FF, '0);
        exp = {ref_mem[1][9'h1FF], {(LW/32){32'hDEAD_BEEF}}};
        act = bus_if.out_data;
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL wrap_511: lane %0d got %h expected %h", bad_lane(act, exp),
                     act[bad_lane(act, exp)*CPX_W +: CPX_W], exp[bad_lane(act, exp)*CPX_W +: CPX_W]);
        end
        repeat (LAT) apply(1'b0, 1'b0, 9'd0, 9'd0, '0);
        exp = ref_read(9'd0);
        act = bus_if.out_data;
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL wrap_addr0: lane %0d got %h expected %h", bad_lane(act, exp),
                     act[bad_lane(act, exp)*CPX_W +: CPX_W], exp[bad_lane(act, exp)*CPX_W +: CPX_W]);
        end
    endtask

    task automatic test_reset_midrun();
        logic [OW-1:0] exp;
        logic [OW-1:0] act;
        repeat (LAT) apply(1'b0, 1'b0, 9'd0, 9'd0, '0);
        #2;
        reset = 1'b1;
        #1;
        act = bus_if.out_data;
        n_vec++;
        if (act !== '0) begin
            n_err++;
            $display("FAIL reset_async: lane %0d got %h expected 0", bad_lane(act, '0), act[bad_lane(act, '0)*CPX_W +: CPX_W]);
        end
        // A write attempted during reset must not reach the array.
        bus_if.we = 1'b1;
        bus_if.select = 1'b0;
        bus_if.write_address = 9'd0;
        bus_if.in_data = rand_line();
        repeat (2) @(posedge clk);
        #1;
        act = bus_if.out_data;
        n_vec++;
        if (act !== '0) begin
            n_err++;
            $display("FAIL reset_hold_out: lane %0d got %h expected 0", bad_lane(act, '0), act[bad_lane(act, '0)*CPX_W +: CPX_W]);
        end
        bus_if.we = 1'b0;
        reset = 1'b0;
        repeat (LAT) apply(1'b0, 1'b0, 9'd0, 9'd0, '0);
        exp = ref_read(9'd0);
        act = bus_if.out_data;
        n_vec++;
        if (act !== exp || $isunknown(act)) begin
            n_err++;
            $display("FAIL reset_write_ignored: lane %0d got %h expected %h", bad_lane(act, exp),
                     act[bad_lane(act, exp)*CPX_W +: CPX_W], exp[bad_lane(act, exp)*CPX_W +: CPX_W]);
        end
    endtask

    task automatic test_random();
        logic [OW-1:0] exp_q[$];
        logic [OW-1:0] exp;
        logic [OW-1:0] act;
        logic [ADDR_W-1:0] ra;
        for (int a = 16; a < 32; a++) begin
            apply(1'b1, 1'b0, ADDR_W'(a), 9'd0, rand_line());
            apply(1'b1, 1'b1, ADDR_W'(a), 9'd0, rand_line());
        end
        for (int n = 0; n < 300; n++) begin
            ra = ADDR_W'($urandom_range(16, 31));
            exp_q.push_back(ref_read(ra));
            apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ADDR_W'($urandom_range(16, 31)), ra, rand_line());
            if (exp_q.size() == LAT) begin
                exp = exp_q.pop_front();
                act = bus_if.out_data;
                n_vec++;
                if (act !== exp) begin
                    n_err++;
                    $display("FAIL random[%0d]: lane %0d got %h expected %h", n, bad_lane(act, exp),
                             act[bad_lane(act, exp)*CPX_W +: CPX_W], exp[bad_lane(act, exp)*CPX_W +: CPX_W]);
                end
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_half_write();
        test_isolation();
        test_two_entries();
        test_back_to_back();
        test_collision();
        test_wrap();
        test_reset_midrun();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
